// File: rtl/decoder_serial.sv
// Serial fixed-point decoder: two latent words drive N_OUT threshold units,
// evaluated one output bit per two clocks through a single shared multiplier.
module decoder_serial #(
    parameter int unsigned             WIDTH = 16,
    parameter int unsigned             FRAC  = 12,
    parameter int unsigned             N_OUT = 9,
    parameter logic [N_OUT*WIDTH-1:0]  W_Z1  = '0,
    parameter logic [N_OUT*WIDTH-1:0]  W_Z2  = '0,
    parameter logic [N_OUT*WIDTH-1:0]  BIAS  = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] z1,
    input  logic [WIDTH-1:0] z2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N_OUT-1:0] out,
    output logic             busy
);

    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned AW = 2 * WIDTH + 2;
    localparam int unsigned KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(N_OUT - 1);

    typedef enum logic [1:0] {IDLE, MAC_A, MAC_B, DONE} state_t;

    state_t                  state;
    logic [KW-1:0]           k;
    logic signed [WIDTH-1:0] z1_q;
    logic signed [WIDTH-1:0] z2_q;
    logic signed [AW-1:0]    acc;
    logic [N_OUT-1:0]        out_reg;

    logic signed [WIDTH-1:0] w1_tab [N_OUT];
    logic signed [WIDTH-1:0] w2_tab [N_OUT];
    logic signed [WIDTH-1:0] b_tab  [N_OUT];

    // Unpack the flat parameter vectors into per-bit coefficient tables
    for (genvar i = 0; i < int'(N_OUT); i++) begin : g_tab
        assign w1_tab[i] = W_Z1[i*WIDTH +: WIDTH];
        assign w2_tab[i] = W_Z2[i*WIDTH +: WIDTH];
        assign b_tab[i]  = BIAS[i*WIDTH +: WIDTH];
    end

    logic signed [WIDTH-1:0] mul_a;
    logic signed [WIDTH-1:0] mul_b;
    logic signed [PW-1:0]    prod;
    logic signed [AW-1:0]    prod_ext;
    logic signed [AW-1:0]    bias_ext;
    logic signed [AW-1:0]    sum_b;

    // One multiplier: z1*W_Z1[k] during MAC_A, z2*W_Z2[k] during MAC_B
    always_comb begin
        mul_a    = z1_q;
        mul_b    = w1_tab[k];
        if (state == MAC_B) begin
            mul_a = z2_q;
            mul_b = w2_tab[k];
        end
        prod     = PW'(mul_a) * PW'(mul_b);
        prod_ext = AW'(prod);
        bias_ext = AW'(b_tab[k]) <<< FRAC;
        sum_b    = acc + prod_ext;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            k         <= '0;
            z1_q      <= '0;
            z2_q      <= '0;
            acc       <= '0;
            out_reg   <= '0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        z1_q     <= z1;
                        z2_q     <= z2;
                        k        <= '0;
                        state    <= MAC_A;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                MAC_A: begin
                    acc   <= prod_ext + bias_ext;
                    state <= MAC_B;
                end
                MAC_B: begin
                    // Non-negative pre-activation is sigmoid >= 0.5
                    out_reg[k] <= ~sum_b[AW-1];
                    if (k == K_LAST) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        k     <= k + KW'(1);
                        state <= MAC_A;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    in_ready  <= 1'b1;
                    busy      <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out = out_reg;

endmodule

// File: tb/tb_decoder_serial.sv
// Directed bench for decoder_serial: three coefficient sets share one stimulus stream.
module tb_decoder_serial;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [15:0] z1 = '0;
    logic [15:0] z2 = '0;

    logic       in_ready_a, out_valid_a, busy_a;
    logic [8:0] out_a;
    logic       in_ready_b, out_valid_b, busy_b;
    logic [8:0] out_b;
    logic       in_ready_c, out_valid_c, busy_c;
    logic [8:0] out_c;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decoder_serial #(
        .WIDTH(16), .FRAC(12), .N_OUT(9),
        .W_Z1({9{16'h1000}}),
        .W_Z2({9{16'hF000}}),
        .BIAS({9{16'h0000}})
    ) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .z1(z1), .z2(z2), .out_valid(out_valid_a), .out_ready(out_ready),
        .out(out_a), .busy(busy_a)
    );

    decoder_serial #(
        .WIDTH(16), .FRAC(12), .N_OUT(9),
        .W_Z1({9{16'h0000}}),
        .W_Z2({9{16'h0000}}),
        .BIAS({16'h1000, {4{16'hF000, 16'h1000}}})
    ) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .z1(z1), .z2(z2), .out_valid(out_valid_b), .out_ready(out_ready),
        .out(out_b), .busy(busy_b)
    );

    decoder_serial #(
        .WIDTH(16), .FRAC(12), .N_OUT(9),
        .W_Z1({{8{16'h0000}}, 16'h8000}),
        .W_Z2({{8{16'h0000}}, 16'h8000}),
        .BIAS({{8{16'hF000}}, 16'h7FFF})
    ) dut_c (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_c),
        .z1(z1), .z2(z2), .out_valid(out_valid_c), .out_ready(out_ready),
        .out(out_c), .busy(busy_c)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present a pair for one edge, then scramble the inputs to prove capture
    task automatic accept(input logic [15:0] a, input logic [15:0] b);
        z1 = a;
        z2 = b;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        z1 = ~a;
        z2 = ~b;
    endtask

    task automatic expect_done(input logic [8:0] exp, input string tag);
        int n = 0;
        while (!out_valid_a && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'd18);
        check({tag, "_out"}, 32'(out_a), 32'(exp));
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({tag, "_idle"}, 32'({out_valid_a, in_ready_a, busy_a}), 32'b010);
    endtask

    initial begin
        #1 rst = 1'b0;
        #22;
        check("reset_a", 32'({out_valid_a, busy_a, in_ready_a, out_a}), 32'({3'b001, 9'h000}));
        check("reset_bc", 32'({in_ready_b, busy_b, out_valid_b, in_ready_c, busy_c, out_valid_c}),
              32'b100100);
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic decode, handshake, and the constant-bias pattern
        accept(16'h2000, 16'h1000);
        check("accepted", 32'({in_ready_a, busy_a}), 32'b01);
        expect_done(9'h1FF, "pos");
        check("bias_pattern", 32'(out_b), 32'h155);
        release_out("pos");

        accept(16'h1000, 16'h2000);
        expect_done(9'h000, "neg");
        release_out("neg");

        accept(16'h0C00, 16'h0C00);
        expect_done(9'h1FF, "zero_y");
        check("bias_pattern2", 32'(out_b), 32'h155);
        release_out("zero_y");

        accept(16'hF000, 16'h0000);
        expect_done(9'h000, "neg_z1");
        release_out("neg_z1");

        // Extreme operands: products of +2^30 must not wrap
        accept(16'h8000, 16'h8000);
        expect_done(9'h1FF, "extreme_a");
        check("extreme_c", 32'({out_valid_c, out_c}), 32'({1'b1, 9'h001}));
        release_out("extreme");

        // Backpressure in DONE with stray in_valid pulses
        accept(16'h1000, 16'h2000);
        expect_done(9'h000, "hold");
        for (int i = 0; i < 5; i++) begin
            in_valid = (i % 2 == 0);
            z1 = 16'h7000;
            z2 = 16'h0000;
            @(posedge clk); #1;
            check($sformatf("hold_%0d", i), 32'({out_valid_a, in_ready_a, out_a}),
                  32'({2'b10, 9'h000}));
        end
        in_valid = 1'b0;
        z1 = 16'h2000;
        z2 = 16'h1000;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("b2b_idle", 32'({out_valid_a, in_ready_a}), 32'b01);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("b2b_accept", 32'({in_ready_a, busy_a}), 32'b01);
        expect_done(9'h1FF, "b2b");
        release_out("b2b");

        // Reset mid-run at edge 7 aborts the pair
        accept(16'h1000, 16'h2000);
        repeat (6) begin
            @(posedge clk); #1;
        end
        check("pre_reset", 32'({busy_a, out_a}), 32'({1'b1, 9'h1F8}));
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        check("mid_reset", 32'({out_valid_a, busy_a, in_ready_a, out_a}), 32'({3'b001, 9'h000}));
        repeat (3) begin
            @(posedge clk); #1;
        end
        check("reset_hold", 32'({out_valid_a, busy_a}), 32'b00);
        rst = 1'b1;
        accept(16'h2000, 16'h1000);
        check("post_reset_accept", 32'({in_ready_a, busy_a}), 32'b01);
        expect_done(9'h1FF, "post_reset");
        release_out("post_reset");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/decoder_serial.md
DECODER_SERIAL -- requirements
Module: decoder_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 16: width of each signed fixed-point word.
REQ-002 SHALL have parameter FRAC, default 12: number of fraction bits (Q3.12 two's complement).
REQ-003 SHALL have parameter N_OUT, default 9: number of decoded output bits.
REQ-004 SHALL have parameter W_Z1, default all 16'h0000: N_OUT*WIDTH packed weights for z1; slice k = [k*WIDTH +: WIDTH].
REQ-005 SHALL have parameter W_Z2, default all 16'h0000: N_OUT*WIDTH packed weights for z2, same slicing.
REQ-006 SHALL have parameter BIAS, default all 16'h0000: N_OUT*WIDTH packed biases, same slicing.
REQ-007 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-008 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-009 SHALL have port in_valid, input, 1 bit: latent pair valid.
REQ-010 SHALL have port in_ready, output, 1 bit: block can accept a pair.
REQ-011 SHALL have port z1, input, WIDTH bits: latent a1 from the encoder, signed Q3.12.
REQ-012 SHALL have port z2, input, WIDTH bits: latent a2 from the encoder, signed Q3.12.
REQ-013 SHALL have port out_valid, output, 1 bit: decoded vector valid.
REQ-014 SHALL have port out_ready, input, 1 bit: consumer accepts the vector.
REQ-015 SHALL have port out, output, N_OUT bits: decoded bits; bit k is pixel k.
REQ-016 SHALL have port busy, output, 1 bit: high in MAC_A and MAC_B.

Function
REQ-017 SHALL implement FSM states IDLE, MAC_A, MAC_B, DONE; the reset state is IDLE.
REQ-018 SHALL drive in_ready=1 only in IDLE.
REQ-019 SHALL capture z1 and z2, clear index k to 0, and go to MAC_A on the clk edge where in_valid&&in_ready.
REQ-020 SHALL, in MAC_A, register acc = sext(z1)*sext(W_Z1[k]) + (sext(BIAS[k]) <<< FRAC), with acc 2*WIDTH+2 bits signed, and go to MAC_B.
REQ-021 SHALL, in MAC_B, write out_reg[k] = 1 if (acc + sext(z2)*sext(W_Z2[k])) >= 0, else 0.
REQ-022 SHALL compute the decision at full precision: no truncation, rounding or saturation (equivalent to sigmoid(y) >= 0.5).
REQ-023 SHALL, in MAC_B, increment k and return to MAC_A if k < N_OUT-1; otherwise go to DONE.
REQ-024 SHALL use exactly one signed WIDTH x WIDTH multiplier, shared between MAC_A and MAC_B.
REQ-025 SHALL assert out_valid exactly 2*N_OUT clk edges after the acceptance edge (18 with defaults), i.e. in DONE.
REQ-026 SHALL hold out_valid and out stable in DONE until out_ready=1.
REQ-027 SHALL return to IDLE on an edge where out_valid&&out_ready; in_ready rises the same edge; a new pair is accepted no earlier than the following edge.
REQ-028 SHALL ignore in_valid in MAC_A, MAC_B and DONE; captured z1/z2 SHALL NOT change there.
REQ-029 SHALL drive out from out_reg in every state; bits not yet written in a run retain their previous-run values, and only DONE qualifies out.
REQ-030 SHALL reach a worst-case product of 0x8000*0x8000 = +2^30 without accumulator wraparound.

Reset
REQ-031 SHALL, while rst=0 (asynchronous to clk), force state=IDLE, k=0, acc=0, out_reg=0, captured z1/z2=0.
REQ-032 SHALL, while rst=0, drive out_valid=0, busy=0, in_ready=1, out=0.
REQ-033 SHALL, on rst asserted mid-run (MAC_A/MAC_B/DONE), abort the run with no out_valid pulse for that pair.
REQ-034 SHALL accept a new pair on the first rising edge with rst=1 and in_valid=1.

Verification
REQ-035 SHALL cover: params W_Z1[k]=0x1000, W_Z2[k]=0xF000, BIAS[k]=0; z1=0x2000, z2=0x1000 -> out=9'h1FF, out_valid on edge 18 after acceptance.
REQ-036 SHALL cover: same params; z1=0x1000, z2=0x2000 -> out=9'h000; then z1=z2=0x0C00 (y=0) -> out=9'h1FF.
REQ-037 SHALL cover: W_Z1=W_Z2=0, BIAS[k]=0x1000 for even k and 0xF000 for odd k -> out=9'b101010101 for any z.
REQ-038 SHALL cover: out_ready held low 5 cycles in DONE -> out stable, in_valid pulses ignored; out_ready=1 -> IDLE next edge, then back-to-back second pair decoded correctly.
REQ-039 SHALL cover: rst pulled low at edge 7 of a run -> out_valid, busy and out go 0 immediately; after release, a fresh pair is decoded with correct result and latency.
REQ-040 SHALL cover: W_Z1[0]=0x8000, W_Z2[0]=0x8000, BIAS[0]=0x7FFF, z1=z2=0x8000 -> out[0]=1, with no wraparound.
